// File: rtl/saber_unpack_pkg.sv
// Shared constants, run-state type and byte-swap helper for the Saber public-polynomial
// coefficient unpacker.
package saber_unpack_pkg;

    localparam int COEFF_W        = 13;
    localparam int WORD_W         = 64;
    localparam int NUM_COEFF      = 256;
    localparam int WORDS_PER_POLY = 52;
    localparam int BUF_W          = 2 * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } unpack_state_e;

    // Reverse the byte order of a memory word (byte 0 <-> byte 7).
    function automatic logic [WORD_W-1:0] byte_swap64(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int k = 0; k < WORD_W / 8; k++) begin
            r[8*k +: 8] = w[WORD_W-8-8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/poly_coeff_unpacker.sv
// Streams 256 13-bit coefficients out of 52 packed 64-bit words in external memory.
// Optional build macro UNPACKER_BYTE_SWAP_EN byte-reverses each memory word before use.
module poly_coeff_unpacker
    import saber_unpack_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rd_data,
    output logic              coeff_valid,
    input  logic              coeff_ready,
    output logic [12:0]       a_coeff,
    output logic [7:0]        coeff_idx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = 8;
    localparam int WCNT_W = 6;

    unpack_state_e     state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] words_q, words_d;
    logic              out_q, out_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        idx_q, idx_d;
    logic              rd_en_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              hs_s;
    logic              issue_s;
    logic [WORD_W-1:0] word_s;
    logic [BUF_W-1:0]  buf_sh_s;
    logic [CNT_W-1:0]  cnt_sh_s;

`ifdef UNPACKER_BYTE_SWAP_EN
    assign word_s = byte_swap64(mem_rd_data);
`else
    assign word_s = mem_rd_data;
`endif

    // A handshake consumes the low coefficient before any same-cycle append lands.
    assign hs_s     = valid_q & coeff_ready;
    assign buf_sh_s = hs_s ? (buf_q >> COEFF_W) : buf_q;
    assign cnt_sh_s = hs_s ? (cnt_q - CNT_W'(COEFF_W)) : cnt_q;

    // Next-state: run sequencing, bit-buffer shift/append and read issue.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        out_d   = 1'b0;
        base_d  = base_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        issue_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    base_d  = base_addr;
                    buf_d   = '0;
                    cnt_d   = '0;
                    words_d = '0;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Data returned this cycle belongs to the read issued last cycle.
                out_d = rd_en_q;
                if (out_q) begin
                    buf_d = buf_sh_s | ({{(BUF_W-WORD_W){1'b0}}, word_s} << cnt_sh_s);
                    cnt_d = cnt_sh_s + CNT_W'(WORD_W);
                end else begin
                    buf_d = buf_sh_s;
                    cnt_d = cnt_sh_s;
                end
                if (hs_s) begin
                    idx_d = idx_q + 8'd1;
                end else begin
                    idx_d = idx_q;
                end
                if (hs_s && (idx_q == 8'(NUM_COEFF - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One read in flight at most, and only when the buffer has room for a full word.
        issue_s = (state_d == ST_RUN) && (words_d < WCNT_W'(WORDS_PER_POLY)) &&
                  !out_d && (cnt_d <= CNT_W'(WORD_W));
        if (issue_s) begin
            addr_d  = base_d + ADDR_W'(words_d);
            words_d = words_d + 6'd1;
        end else begin
            addr_d  = addr_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            out_q   <= 1'b0;
            base_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            out_q   <= out_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            rd_en_q <= issue_s;
            valid_q <= (state_d == ST_RUN) && (cnt_d >= CNT_W'(COEFF_W));
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = addr_q;
    assign coeff_valid = valid_q;
    assign a_coeff     = buf_q[COEFF_W-1:0];
    assign coeff_idx   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
